// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory pipeline stage: op encodings and FSM states.
package mem_stage_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_PASS = 3'd1,
    OP_LD   = 3'd2,
    OP_ST   = 3'd3,
    OP_PUSH = 3'd4,
    OP_POP  = 3'd5,
    OP_CALL = 3'd6,
    OP_RET  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  // Every op except NOP and PASS goes through the memory port.
  function automatic logic op_is_access(input op_e op);
    return (op != OP_NOP) && (op != OP_PASS);
  endfunction

endpackage

// File: rtl/mem_stage_addr_gen.sv
// Combinational access decode: address, write enable, lane enables, stack
// over/underflow detection and the pointer values that apply once granted.
module mem_stage_addr_gen
  import mem_stage_pkg::*;
#(
  parameter int                LANES   = 2,
  parameter int                ADDR_W  = 17,
  parameter int                SP_W    = 16,
  parameter int                CSP_W   = 8,
  parameter logic [ADDR_W-1:0] SP_BASE = 17'h10000,
  parameter logic [ADDR_W-1:0] CS_BASE = 17'h1FF00,
  parameter logic [SP_W-1:0]   SP_RST  = 16'hFFFF,
  parameter logic [CSP_W-1:0]  CSP_RST = 8'hFF
) (
  input  op_e               op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LANES-1:0]  be_i,
  input  logic [SP_W-1:0]   sp_i,
  input  logic [CSP_W-1:0]  csp_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              we_o,
  output logic [LANES-1:0]  be_o,
  output logic              fault_o,
  output logic [SP_W-1:0]   sp_nxt_o,
  output logic [CSP_W-1:0]  csp_nxt_o
);

  localparam int SP_PAD  = ADDR_W - SP_W;
  localparam int CSP_PAD = ADDR_W - CSP_W;

  logic [SP_W-1:0]  sp_dec,  sp_inc;
  logic [CSP_W-1:0] csp_dec, csp_inc;

  assign sp_dec  = sp_i - SP_W'(1);
  assign sp_inc  = sp_i + SP_W'(1);
  assign csp_dec = csp_i - CSP_W'(1);
  assign csp_inc = csp_i + CSP_W'(1);

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    addr_o    = addr_i;
    we_o      = 1'b0;
    be_o      = '1;
    fault_o   = 1'b0;
    sp_nxt_o  = sp_i;
    csp_nxt_o = csp_i;
    case (op_i)
      OP_ST: begin
        we_o = 1'b1;
        be_o = be_i;
      end
      OP_PUSH: begin
        addr_o   = SP_BASE + {{SP_PAD{1'b0}}, sp_dec};
        we_o     = 1'b1;
        fault_o  = (sp_i == '0);
        sp_nxt_o = sp_dec;
      end
      OP_POP: begin
        addr_o   = SP_BASE + {{SP_PAD{1'b0}}, sp_i};
        fault_o  = (sp_i == SP_RST);
        sp_nxt_o = sp_inc;
      end
      OP_CALL: begin
        addr_o    = CS_BASE + {{CSP_PAD{1'b0}}, csp_dec};
        we_o      = 1'b1;
        fault_o   = (csp_i == '0);
        csp_nxt_o = csp_dec;
      end
      OP_RET: begin
        addr_o    = CS_BASE + {{CSP_PAD{1'b0}}, csp_i};
        fault_o   = (csp_i == CSP_RST);
        csp_nxt_o = csp_inc;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_seq.sv
// Memory pipeline stage: runs loads, stores and stack ops over a req/gnt/rvalid
// port, owns SP/CSP, registers the MEM/WB result and stalls the front end.
module mem_stage_seq
  import mem_stage_pkg::*;
#(
  parameter int                LANES   = 2,
  parameter int                LANE_W  = 8,
  parameter int                ADDR_W  = 17,
  parameter int                SP_W    = 16,
  parameter int                CSP_W   = 8,
  parameter logic [ADDR_W-1:0] SP_BASE = 17'h10000,
  parameter logic [ADDR_W-1:0] CS_BASE = 17'h1FF00,
  parameter logic [SP_W-1:0]   SP_RST  = 16'hFFFF,
  parameter logic [CSP_W-1:0]  CSP_RST = 8'hFF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [2:0]              in_op,
  input  logic [ADDR_W-1:0]       in_addr,
  input  logic [LANES*LANE_W-1:0] in_data,
  input  logic [LANES-1:0]        in_be,
  input  logic                    stall_in,
  output logic                    stall_out,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [LANES*LANE_W-1:0] mem_wdata,
  output logic [LANES-1:0]        mem_be,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [LANES*LANE_W-1:0] mem_rdata,
  output logic                    out_valid,
  output logic [LANES*LANE_W-1:0] out_data,
  output logic [SP_W-1:0]         sp,
  output logic [CSP_W-1:0]        csp,
  output logic                    fault
);

  localparam int DATA_W = LANES * LANE_W;

  state_e              state_q,     state_d;
  logic                we_q,        we_d;
  logic [ADDR_W-1:0]   addr_q,      addr_d;
  logic [DATA_W-1:0]   wdata_q,     wdata_d;
  logic [LANES-1:0]    be_q,        be_d;
  logic [SP_W-1:0]     sp_pend_q,   sp_pend_d;
  logic [CSP_W-1:0]    csp_pend_q,  csp_pend_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q,  out_data_d;
  logic [SP_W-1:0]     sp_q,        sp_d;
  logic [CSP_W-1:0]    csp_q,       csp_d;
  logic                fault_q,     fault_d;

  op_e                 op;
  logic                accept;
  logic [ADDR_W-1:0]   ag_addr;
  logic                ag_we;
  logic [LANES-1:0]    ag_be;
  logic                ag_fault;
  logic [SP_W-1:0]     ag_sp_nxt;
  logic [CSP_W-1:0]    ag_csp_nxt;

  assign op     = op_e'(in_op);
  assign accept = in_valid & ~stall_out;

  mem_stage_addr_gen #(
    .LANES   (LANES),
    .ADDR_W  (ADDR_W),
    .SP_W    (SP_W),
    .CSP_W   (CSP_W),
    .SP_BASE (SP_BASE),
    .CS_BASE (CS_BASE),
    .SP_RST  (SP_RST),
    .CSP_RST (CSP_RST)
  ) u_addr_gen (
    .op_i      (op),
    .addr_i    (in_addr),
    .be_i      (in_be),
    .sp_i      (sp_q),
    .csp_i     (csp_q),
    .addr_o    (ag_addr),
    .we_o      (ag_we),
    .be_o      (ag_be),
    .fault_o   (ag_fault),
    .sp_nxt_o  (ag_sp_nxt),
    .csp_nxt_o (ag_csp_nxt)
  );

  // mem_req decodes straight from the state so a reset drops it without waiting for an edge.
  assign mem_req   = (state_q == ST_REQ);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sp        = sp_q;
  assign csp       = csp_q;
  assign fault     = fault_q;
  assign stall_out = (state_q != ST_IDLE) | (out_valid_q & stall_in);

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    sp_pend_d   = sp_pend_q;
    csp_pend_d  = csp_pend_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    sp_d        = sp_q;
    csp_d       = csp_q;
    fault_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (out_valid_q && !stall_in) out_valid_d = 1'b0;
        if (accept) begin
          if (op == OP_PASS) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
          end else if (op_is_access(op)) begin
            if (ag_fault) begin
              fault_d     = 1'b1;
              out_valid_d = 1'b1;
              out_data_d  = '0;
            end else begin
              // Pointer targets are fixed at accept; nothing else moves SP/CSP until the grant.
              state_d    = ST_REQ;
              we_d       = ag_we;
              addr_d     = ag_addr;
              wdata_d    = in_data;
              be_d       = ag_be;
              sp_pend_d  = ag_sp_nxt;
              csp_pend_d = ag_csp_nxt;
            end
          end
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          sp_d  = sp_pend_q;
          csp_d = csp_pend_q;
          if (we_q) begin
            state_d     = ST_HOLD;
            out_valid_d = 1'b1;
            out_data_d  = wdata_q;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (mem_rvalid) begin
          state_d     = ST_HOLD;
          out_valid_d = 1'b1;
          out_data_d  = mem_rdata;
        end
      end
      ST_HOLD: begin
        if (!stall_in) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      sp_pend_q   <= SP_RST;
      csp_pend_q  <= CSP_RST;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sp_q        <= SP_RST;
      csp_q       <= CSP_RST;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      sp_pend_q   <= sp_pend_d;
      csp_pend_q  <= csp_pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sp_q        <= sp_d;
      csp_q       <= csp_d;
      fault_q     <= fault_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_seq.sv
// Self-checking bench for mem_stage_seq: memory responder, scoreboard model
// with per-cycle compare, and directed scenarios with literal expectations.
module tb_mem_stage_seq;
  import mem_stage_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [2:0]  in_op;
  logic [16:0] in_addr;
  logic [15:0] in_data;
  logic [1:0]  in_be;
  logic        stall_in;
  logic        stall_out;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [16:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic [1:0]  mem_be;
  logic        out_valid;
  logic [15:0] out_data;
  logic [15:0] sp;
  logic [7:0]  csp;
  logic        fault;

  always #5 clock = ~clock;

  mem_stage_seq dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_op(in_op),
    .in_addr(in_addr), .in_data(in_data), .in_be(in_be), .stall_in(stall_in),
    .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_data(out_data),
    .sp(sp), .csp(csp), .fault(fault)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct { logic [16:0] addr; logic we; logic [1:0] be; logic [15:0] wdata; } acc_t;
  typedef struct { logic [15:0] data; logic [15:0] sp; logic [7:0] csp; } res_t;

  acc_t exp_acc[$];
  res_t exp_res[$];
  res_t cmp_r;
  int   m_sp, m_csp;
  logic [15:0] mem [logic [16:0]];

  int gnt_delay = 0, rv_delay = 1, wait_cnt = 0, rv_cnt = 0;
  logic [15:0] rd_word = '0;
  int req_cycles = 0, fault_seen = 0, fault_exp = 0, rv_seen = 0;

  function automatic logic [15:0] mem_peek(input logic [16:0] a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  // Architectural model: expected access and result of one accepted op.
  task automatic model_op(input op_e op, input logic [16:0] a, input logic [15:0] d,
                          input logic [1:0] be);
    acc_t x;
    res_t r;
    bit   has_acc = 1'b1;
    bit   flt = 1'b0;
    x = '{addr: a, we: 1'b0, be: 2'b11, wdata: d};
    r = '{data: d, sp: 16'h0, csp: 8'h0};
    case (op)
      OP_NOP:  return;
      OP_PASS: has_acc = 1'b0;
      OP_LD:   r.data = mem_peek(a);
      OP_ST:   begin x.we = 1'b1; x.be = be; end
      OP_PUSH: if (m_sp == 0) flt = 1'b1;
               else begin x.addr = 17'((32'h10000 + m_sp - 1) & 32'h1FFFF); x.we = 1'b1; m_sp--; end
      OP_POP:  if (m_sp == 16'hFFFF) flt = 1'b1;
               else begin x.addr = 17'((32'h10000 + m_sp) & 32'h1FFFF); r.data = mem_peek(x.addr); m_sp++; end
      OP_CALL: if (m_csp == 0) flt = 1'b1;
               else begin x.addr = 17'((32'h1FF00 + m_csp - 1) & 32'h1FFFF); x.we = 1'b1; m_csp--; end
      OP_RET:  if (m_csp == 8'hFF) flt = 1'b1;
               else begin x.addr = 17'((32'h1FF00 + m_csp) & 32'h1FFFF); r.data = mem_peek(x.addr); m_csp++; end
      default: ;
    endcase
    if (flt) begin
      has_acc = 1'b0;
      r.data  = 16'h0000;
      fault_exp++;
    end
    r.sp  = 16'(m_sp);
    r.csp = 8'(m_csp);
    if (has_acc) exp_acc.push_back(x);
    exp_res.push_back(r);
  endtask

  // Memory responder with programmable grant and read-data delays.
  initial begin
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clock); #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (reset) wait_cnt = 0;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin mem_rvalid = 1'b1; mem_rdata = rd_word; rv_seen++; end
      end else if (mem_req) begin
        if (wait_cnt >= gnt_delay) begin
          mem_gnt  = 1'b1;
          wait_cnt = 0;
          if (mem_we) begin
            logic [15:0] w;
            w = mem_peek(mem_addr);
            if (mem_be[0]) w[7:0]  = mem_wdata[7:0];
            if (mem_be[1]) w[15:8] = mem_wdata[15:8];
            mem[mem_addr] = w;
          end else begin
            rd_word = mem_peek(mem_addr);
            rv_cnt  = rv_delay;
          end
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clock) begin
    if (!reset) begin
      if (mem_req) begin
        req_cycles++;
        check("req_expected", 32'(exp_acc.size() != 0), 32'd1);
        if (exp_acc.size() != 0) begin
          check("acc_addr", 32'(mem_addr), 32'(exp_acc[0].addr));
          check("acc_we",   32'(mem_we),   32'(exp_acc[0].we));
          check("acc_be",   32'(mem_be),   32'(exp_acc[0].be));
          if (exp_acc[0].we) check("acc_wdata", 32'(mem_wdata), 32'(exp_acc[0].wdata));
          if (mem_gnt) void'(exp_acc.pop_front());
        end
      end
      if (fault) begin
        fault_seen++;
        check("fault_result", {15'h0, out_valid, out_data}, {15'h0, 1'b1, 16'h0000});
      end
      if (out_valid && !stall_in) begin
        check("res_expected", 32'(exp_res.size() != 0), 32'd1);
        if (exp_res.size() != 0) begin
          cmp_r = exp_res.pop_front();
          check("res_data", 32'(out_data), 32'(cmp_r.data));
          check("res_sp",   32'(sp),       32'(cmp_r.sp));
          check("res_csp",  32'(csp),      32'(cmp_r.csp));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic issue_op(input op_e op, input logic [16:0] a, input logic [15:0] d,
                          input logic [1:0] be);
    int n = 0;
    in_valid = 1'b1; in_op = op; in_addr = a; in_data = d; in_be = be;
    @(negedge clock);
    while (stall_out && n < 200) begin n++; @(negedge clock); end
    check("accept_in_time", 32'(n < 200), 32'd1);
    model_op(op, a, d, be);
    tick();
    in_valid = 1'b0; in_op = OP_NOP;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_res.size() != 0 || stall_out) && n < 200) begin tick(); n++; end
    check("done_in_time", 32'(n < 200), 32'd1);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    check("result_in_time", 32'(lat < 100), 32'd1);
  endtask

  task automatic do_reset_abort();
    reset = 1'b1;
    exp_acc.delete();
    exp_res.delete();
    m_sp = 16'hFFFF; m_csp = 8'hFF;
    @(posedge clock); #2;
    reset = 1'b0;
  endtask

  initial begin
    int rc, fs, lat;
    reset = 1'b1; in_valid = 1'b0; in_op = OP_NOP; in_addr = '0; in_data = '0;
    in_be = '0; stall_in = 1'b0;
    m_sp = 16'hFFFF; m_csp = 8'hFF;
    mem[17'h00040] = 16'h1234;

    repeat (2) @(posedge clock); #1;
    check("rst_req",       32'(mem_req),   32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'h0);
    check("rst_sp",        32'(sp),        32'hFFFF);
    check("rst_csp",       32'(csp),       32'hFF);
    check("rst_stall",     32'(stall_out), 32'd0);
    check("rst_fault",     32'(fault),     32'd0);
    check("rst_addr",      32'(mem_addr),  32'h0);
    reset = 1'b0;
    tick();

    issue_op(OP_PASS, 17'h0, 16'hBEEF, 2'b00);
    check("pass_valid", 32'(out_valid), 32'd1);
    check("pass_data",  32'(out_data),  32'hBEEF);
    check("pass_stall", 32'(stall_out), 32'd0);
    wait_done();

    gnt_delay = 3;
    rc = req_cycles;
    issue_op(OP_ST, 17'h00123, 16'hA55A, 2'b01);
    wait_done();
    check("st_req_cycles", 32'(req_cycles - rc), 32'd4);
    check("st_mem_lane0",  32'(mem_peek(17'h00123)), 32'h005A);
    gnt_delay = 0;

    rv_delay = 2;
    issue_op(OP_LD, 17'h00040, 16'h0000, 2'b11);
    lat = 0;
    while (!out_valid && lat < 20) begin
      check("ld_stall_busy", 32'(stall_out), 32'd1);
      tick(); lat++;
    end
    check("ld_latency",    32'(lat),       32'd3);
    check("ld_data",       32'(out_data),  32'h1234);
    check("ld_stall_hold", 32'(stall_out), 32'd1);
    wait_done();
    rv_delay = 1;

    issue_op(OP_PUSH, 17'h0, 16'h00AA, 2'b00);
    wait_done();
    check("push_sp",  32'(sp), 32'hFFFE);
    check("push_mem", 32'(mem_peek(17'h1FFFE)), 32'h00AA);
    issue_op(OP_POP, 17'h0, 16'h0000, 2'b00);
    wait_result(lat);
    check("pop_data", 32'(out_data), 32'h00AA);
    wait_done();
    check("pop_sp", 32'(sp), 32'hFFFF);

    issue_op(OP_CALL, 17'h0, 16'h5678, 2'b00);
    stall_in = 1'b1;
    wait_result(lat);
    for (int i = 0; i < 3; i++) begin
      check("call_hold_data",  32'(out_data),  32'h5678);
      check("call_hold_stall", 32'(stall_out), 32'd1);
      tick();
    end
    stall_in = 1'b0;
    wait_done();
    check("call_csp", 32'(csp), 32'hFE);
    issue_op(OP_RET, 17'h0, 16'h0000, 2'b00);
    wait_result(lat);
    check("ret_data", 32'(out_data), 32'h5678);
    wait_done();
    check("ret_csp", 32'(csp), 32'hFF);

    rc = req_cycles; fs = fault_seen;
    issue_op(OP_POP, 17'h0, 16'h1111, 2'b00);
    check("pop_fault", 32'(fault), 32'd1);
    wait_done();
    check("fault_pulse", 32'(fault), 32'd0);
    issue_op(OP_RET, 17'h0, 16'h2222, 2'b00);
    check("ret_fault", 32'(fault), 32'd1);
    wait_done();
    check("fault_no_req", 32'(req_cycles - rc), 32'd0);
    check("fault_count",  32'(fault_seen - fs), 32'd2);
    check("fault_sp",     32'(sp),  32'hFFFF);
    check("fault_csp",    32'(csp), 32'hFF);

    in_valid = 1'b1; in_op = OP_PASS; in_data = 16'h7777; stall_in = 1'b1;
    @(negedge clock);
    check("bp_first_accept", 32'(stall_out), 32'd0);
    model_op(OP_PASS, 17'h0, 16'h7777, 2'b00);
    tick();
    in_data = 16'h8888;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data",  32'(out_data),  32'h7777);
      check("bp_stall", 32'(stall_out), 32'd1);
      tick();
    end
    stall_in = 1'b0;
    @(negedge clock);
    check("bp_release", 32'(stall_out), 32'd0);
    model_op(OP_PASS, 17'h0, 16'h8888, 2'b00);
    tick();
    in_valid = 1'b0; in_op = OP_NOP;
    check("bp_next_data", 32'(out_data), 32'h8888);
    wait_done();

    issue_op(OP_PUSH, 17'h0, 16'h0BB0, 2'b00);
    wait_done();
    check("pre_rst_sp", 32'(sp), 32'hFFFE);
    gnt_delay = 50;
    issue_op(OP_LD, 17'h00040, 16'h0000, 2'b11);
    tick();
    check("pre_rst_req", 32'(mem_req), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_req_async", 32'(mem_req),   32'd0);
    check("rst_mid_sp",    32'(sp),        32'hFFFF);
    check("rst_mid_csp",   32'(csp),       32'hFF);
    check("rst_mid_stall", 32'(stall_out), 32'd0);
    do_reset_abort();
    gnt_delay = 0;
    tick();

    rc = rv_seen;
    rv_delay = 4;
    issue_op(OP_LD, 17'h00040, 16'h0000, 2'b11);
    tick();
    #2;
    do_reset_abort();
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("late_rvalid_valid", 32'(out_valid), 32'd0);
      check("late_rvalid_data",  32'(out_data),  32'h0);
    end
    check("late_rvalid_seen", 32'(rv_seen - rc), 32'd1);
    rv_delay = 1;
    tick();

    issue_op(OP_PASS, 17'h0, 16'h600D, 2'b00);
    check("final_pass", 32'(out_data), 32'h600D);
    wait_done();
    check("fault_total",   32'(fault_seen),     32'(fault_exp));
    check("acc_drained",   32'(exp_acc.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
